// File: rtl/feeder_pkg.sv
// Shared types and defaults for the NAND program feeder.
package feeder_pkg;

    localparam int PROG_LEN_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRESET,
        RUN,
        SETTLE,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/nand_program_feeder_prog_shifter.sv
// Parallel-load, LSB-first shift register that supplies the serial program bit.
module prog_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         ser
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {1'b0, sr[W-1:1]};
        end
    end

    assign ser = sr[0];

endmodule

// File: rtl/nand_program_feeder.sv
// Streams a captured program into a 1-bit NAND accumulator core and captures its result.
// Optional FEEDER_MODEL_EN adds an internal reference accumulator that drives mismatch_o.
//
// state  | meaning
// IDLE   | waiting for start_i, outputs quiet
// PRESET | one-cycle preset pulse to the core
// RUN    | PROG_LEN cycles, one program bit per cycle, bit 0 first
// SETTLE | core output settles, captured into result_o on the closing edge
// DONE   | one-cycle done_o pulse, result_o valid
module nand_program_feeder
    import feeder_pkg::*;
#(
    parameter int PROG_LEN = PROG_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [PROG_LEN-1:0] prog_i,
    input  logic                acc_i,
    output logic                preset_o,
    output logic                d_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                result_o,
    output logic                mismatch_o
);

    localparam int CNT_W = $clog2(PROG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROG_LEN - 1);

    feeder_state_e    state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ser;
    logic             load;
    logic             shift;

    prog_shifter #(.W(PROG_LEN)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (prog_i),
        .ser   (ser)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            result_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt <= '0;
            end else if (state == RUN && cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (state == SETTLE) begin
                result_o <= acc_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        preset_o  = 1'b0;
        d_o       = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    load      = 1'b1;
                    state_nxt = PRESET;
                end
            end
            PRESET: begin
                preset_o  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                d_o   = ser;
                shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy_o    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef FEEDER_MODEL_EN
    logic model_acc;

    // Reference accumulator: first RUN bit loads, later bits NAND into it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            model_acc  <= 1'b0;
            mismatch_o <= 1'b0;
        end else begin
            if (load) begin
                mismatch_o <= 1'b0;
            end
            if (state == RUN) begin
                model_acc <= (cnt == '0) ? ser : ~(ser & model_acc);
            end
            if (state == SETTLE) begin
                mismatch_o <= (model_acc != acc_i);
            end
        end
    end
`else
    assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_nand_program_feeder.sv
// Randomized self-checking bench for nand_program_feeder with a behavioural NAND core on acc_i.
module tb_nand_program_feeder;

    localparam int PL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [PL-1:0] prog_i = '0;
    logic          acc_i;
    logic          preset_o, d_o, busy_o, done_o, result_o, mismatch_o;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit inv = 1'b0;

    always #5 clk = ~clk;

    nand_program_feeder #(.PROG_LEN(PL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .prog_i     (prog_i),
        .acc_i      (acc_i),
        .preset_o   (preset_o),
        .d_o        (d_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .mismatch_o (mismatch_o)
    );

    // Behavioural 1-bit NAND accumulator core: the bit after a preset loads, later bits NAND in.
    logic core_acc = 1'b0;
    logic core_first = 1'b0;
    always @(posedge clk) begin
        if (preset_o) begin
            core_first <= 1'b1;
        end else if (core_first) begin
            core_acc   <= d_o;
            core_first <= 1'b0;
        end else begin
            core_acc <= ~(d_o & core_acc);
        end
    end
    assign acc_i = core_acc ^ inv;

    function automatic logic fold(input logic [PL-1:0] p);
        logic a;
        a = p[0];
        for (int k = 1; k < PL; k++) a = ~(p[k] & a);
        return a;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within a run (0 idle, 1 preset, 2..PL+1 run, PL+2 settle, PL+3 done).
    int            pos = 0;
    logic [PL-1:0] cap = '0;
    logic          exp_res = 1'b0;
    logic          exp_mm = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pos = 0; cap = '0; exp_res = 1'b0; exp_mm = 1'b0;
        end else if (pos == 0) begin
            if (start_i) begin
                cap = prog_i; pos = 1; exp_mm = 1'b0;
            end
        end else if (pos == PL + 2) begin
            exp_res = fold(cap) ^ inv;
`ifdef FEEDER_MODEL_EN
            exp_mm = inv;
`else
            exp_mm = 1'b0;
`endif
            pos++;
        end else if (pos == PL + 3) begin
            pos = 0;
        end else begin
            pos++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_o",     busy_o,     pos != 0);
            check("preset_o",   preset_o,   pos == 1);
            check("d_o",        d_o,        (pos >= 2 && pos <= PL + 1) ? cap[pos-2] : 1'b0);
            check("done_o",     done_o,     pos == PL + 3);
            check("result_o",   result_o,   exp_res);
            check("mismatch_o", mismatch_o, exp_mm);
        end
    end

    // One run from IDLE; returns done latency from busy rise, d_o sequence, result at SETTLE and DONE.
    task automatic run_rec(input logic [PL-1:0] p, input bit hold, input bit chg, input int rst_at,
                           output int lat, output logic [PL-1:0] dseq,
                           output logic res_settle, output logic res, output logic mm);
        int b;
        b = -1; lat = -1; dseq = '0; res_settle = 1'b0; res = 1'b0; mm = 1'b0;
        @(negedge clk);
        prog_i = p;
        start_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            if (b < 0 && busy_o) b = i;
            if (b >= 0) begin
                if (i - b >= 1 && i - b <= PL) dseq[i-b-1] = d_o;
                if (i - b == 3 && chg) prog_i = ~p;
                if (i - b == PL + 1) res_settle = result_o;
                if (i - b == rst_at) begin
                    rst_n = 1'b0;
                    start_i = 1'b0;
                    lat = 0;
                    break;
                end
                if (done_o) begin
                    lat = i - b;
                    res = result_o;
                    mm = mismatch_o;
                    start_i = 1'b0;
                    break;
                end
            end
        end
        if (lat < 0) check("run_timeout", 1'b0, 1'b1);
    endtask

    int            lat;
    logic [PL-1:0] dseq;
    logic          rs, res, mm;
    logic [PL-1:0] p;
    bit            hold, chg;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_result", result_o, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_rec(8'h01, 0, 0, -1, lat, dseq, rs, res, mm);
        check_int("lat_01", lat, 10);
        check_int("dseq_01", int'(dseq), 8'h01);
        check("res_01", res, 1'b1);
        check("mm_01", mm, 1'b0);

        run_rec(8'hFF, 0, 0, -1, lat, dseq, rs, res, mm);
        check_int("dseq_ff", int'(dseq), 8'hFF);
        check("res_ff", res, 1'b0);

        run_rec(8'h00, 0, 0, -1, lat, dseq, rs, res, mm);
        check("res_00", res, 1'b1);
        run_rec(8'hFF, 0, 0, -1, lat, dseq, rs, res, mm);
        check("res_held_to_settle", rs, 1'b1);
        check("res_ff_after", res, 1'b0);

        // start held high with prog_i changed mid-run
        run_rec(8'hA5, 1, 1, -1, lat, dseq, rs, res, mm);
        check_int("dseq_hold", int'(dseq), 8'hA5);
        check_int("lat_hold", lat, 10);
        repeat (3) @(negedge clk);
        check("no_second_run", busy_o, 1'b0);

        // reset in RUN cycle 3
        run_rec(8'h3C, 0, 0, 4, lat, dseq, rs, res, mm);
        @(negedge clk);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_result", result_o, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_rec(8'h3C, 0, 0, -1, lat, dseq, rs, res, mm);
        check_int("fresh_lat", lat, 10);
        check_int("fresh_dseq", int'(dseq), 8'h3C);
        check("fresh_res", res, fold(8'h3C));

        // core output inverted during the run
        inv = 1'b1;
        run_rec(8'h01, 0, 0, -1, lat, dseq, rs, res, mm);
        check("inv_res", res, 1'b0);
`ifdef FEEDER_MODEL_EN
        check("inv_mm", mm, 1'b1);
`else
        check("inv_mm", mm, 1'b0);
`endif
        @(negedge clk);
        inv = 1'b0;

        for (int n = 0; n < 30; n++) begin
            p = PL'($urandom);
            hold = bit'($urandom_range(0, 1));
            chg = bit'($urandom_range(0, 1));
            run_rec(p, hold, chg, -1, lat, dseq, rs, res, mm);
            check_int("rnd_dseq", int'(dseq), int'(p));
            check("rnd_res", res, fold(p));
            check_int("rnd_lat", lat, 10);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
